// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        IRWrite;
  logic        IorD;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [1:0]  ALUOp;
  logic [2:0]  State;
  logic        IllegalOp;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, IRWrite, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, State, IllegalOp
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, IRWrite, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, State, IllegalOp
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// latched instruction class and a sticky illegal-opcode trap state.
module multicycle_controller (
  input  logic clk,
  input  logic rst_n,
  multicycle_controller_if.master bus
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [2:0] CL_NOP     = 3'd0;
  localparam logic [2:0] CL_RTYPE   = 3'd1;
  localparam logic [2:0] CL_LDUR    = 3'd2;
  localparam logic [2:0] CL_STUR    = 3'd3;
  localparam logic [2:0] CL_CBZ     = 3'd4;
  localparam logic [2:0] CL_ILLEGAL = 3'd5;

  logic [2:0] state_reg, state_next;
  logic [2:0] class_reg, class_next;
  logic [2:0] op_class;
  logic       illegal_reg;

  always_comb begin
    casez (bus.Opcode)
      11'b00000000000: op_class = CL_NOP;
      11'b11111000010: op_class = CL_LDUR;
      11'b11111000000: op_class = CL_STUR;
      11'b10110100???: op_class = CL_CBZ;
      11'b1??0101?000: op_class = CL_RTYPE;
      default:         op_class = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    class_next = class_reg;
    case (state_reg)
      FETCH:  if (bus.MemReady) state_next = DECODE;
      DECODE: begin
        class_next = op_class;
        case (op_class)
          CL_NOP:     state_next = FETCH;
          CL_ILLEGAL: state_next = ERROR;
          default:    state_next = EXEC;
        endcase
      end
      EXEC: begin
        case (class_reg)
          CL_RTYPE:         state_next = WB;
          CL_LDUR, CL_STUR: state_next = MEM;
          default:          state_next = FETCH;
        endcase
      end
      MEM: if (bus.MemReady) state_next = (class_reg == CL_LDUR) ? WB : FETCH;
      WB:     state_next = FETCH;
      ERROR:  state_next = ERROR;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      class_reg   <= CL_NOP;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
      if (state_next == ERROR) illegal_reg <= 1'b1;
    end
  end

  // DECODE needs the live opcode for Reg2Loc: the class is only latched at the end of that cycle.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.Reg2Loc  = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.Branch   = 1'b0;
    bus.ALUOp    = 2'b00;
    case (state_reg)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      DECODE: bus.Reg2Loc = (op_class == CL_STUR) || (op_class == CL_CBZ);
      EXEC: begin
        case (class_reg)
          CL_RTYPE: bus.ALUOp = 2'b10;
          CL_LDUR, CL_STUR: bus.ALUSrc = 1'b1;
          CL_CBZ: begin
            bus.ALUOp   = 2'b01;
            bus.Reg2Loc = 1'b1;
            bus.Branch  = 1'b1;
            bus.PCWrite = bus.Zero;
          end
          default: ;
        endcase
      end
      MEM: begin
        bus.IorD = 1'b1;
        if (class_reg == CL_LDUR) bus.MemRead = 1'b1;
        if (class_reg == CL_STUR) begin
          bus.MemWrite = 1'b1;
          bus.Reg2Loc  = 1'b1;
        end
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (class_reg == CL_LDUR);
      end
      default: ;
    endcase
  end

  assign bus.State     = state_reg;
  assign bus.IllegalOp = illegal_reg;
endmodule
